// File: rtl/seq_fixed_multiplier_if.sv
// Handshake and operand/result bundle for the sequential fixed-point multiplier.
// The requester drives the operands and start. The multiplier drives the result and status.
interface seq_fixed_multiplier_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic [2*WIDTH-1:0]   A;
    logic [2*WIDTH-1:0]   B;
    logic [2*WIDTH-1:0]   Result;
    logic                 done;
    logic                 busy;
    logic                 overflow;

    modport master (
        output start, A, B,
        input  Result, done, busy, overflow
    );

    modport slave (
        input  start, A, B,
        output Result, done, busy, overflow
    );
endinterface

// File: rtl/seq_fixed_multiplier.sv
// Unsigned fixed-point multiplier using iterative shift-and-add.
// The operands and the result use the same 2*WIDTH-bit QWIDTH.FRACTIONAL_BITS format.
// The product forms over 2*WIDTH cycles, then it is truncated.
// If the integer part of the product does not fit the format, the result saturates.
module seq_fixed_multiplier #(
    parameter int WIDTH           = 8,
    parameter int FRACTIONAL_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    seq_fixed_multiplier_if.slave bus
);
    localparam int OP_W   = 2 * WIDTH;
    localparam int FULL_W = 4 * WIDTH;
    localparam int CNT_W  = $clog2(OP_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OP_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [FULL_W-1:0] a_reg;
    logic [OP_W-1:0]   b_reg;
    logic [FULL_W-1:0] acc;
    logic [CNT_W-1:0]  cnt;

    // The product bits above the output format. If any of them is set, the product does not fit.
    logic [FULL_W-OP_W-FRACTIONAL_BITS-1:0] acc_high;
    logic [OP_W-1:0]                        acc_window;

    assign acc_high   = acc[FULL_W-1 : OP_W+FRACTIONAL_BITS];
    assign acc_window = acc[OP_W+FRACTIONAL_BITS-1 : FRACTIONAL_BITS];

    // busy covers the whole operation: from the start edge through the DONE state.
    assign bus.busy = (state != IDLE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. start is only looked at in IDLE, so a request while busy is dropped.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                if (cnt == CNT_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: latch the operands, add and shift once per bit, then saturate or truncate into Result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg        <= '0;
            b_reg        <= '0;
            acc          <= '0;
            cnt          <= '0;
            bus.Result   <= '0;
            bus.overflow <= 1'b0;
            bus.done     <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_reg <= {{(FULL_W-OP_W){1'b0}}, bus.A};
                        b_reg <= bus.B;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    if (b_reg[0]) begin
                        acc <= acc + a_reg;
                    end
                    a_reg <= a_reg << 1;
                    b_reg <= b_reg >> 1;
                    cnt   <= cnt + CNT_ONE;
                end
                DONE: begin
                    // Truncate toward zero. There is no rounding bit, so this matches the truncating divider.
                    if (acc_high != '0) begin
                        bus.Result   <= '1;
                        bus.overflow <= 1'b1;
                    end else begin
                        bus.Result   <= acc_window;
                        bus.overflow <= 1'b0;
                    end
                    bus.done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end
endmodule
